// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, reset PC and
// the J-format target field width.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        ISSUE    = 2'd1,
        SYS_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    // Base of the text segment.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // J/JAL carry a 26-bit word index in inst[25:0].
    localparam int TGT_W = 26;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection for one issued instruction, plus the
// alignment check on redirect targets. Syscall outranks every redirect.
module next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic [TGT_W-1:0] inst_i,
    input  logic [WIDTH-1:0] rs_value_i,
    input  logic             jump_i,
    input  logic             jr_i,
    input  logic             branch_i,
    input  logic             branch_taken_i,
    input  logic             syscall_i,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             misaligned_o
);

    logic [WIDTH-1:0] br_off;
    logic             redirect;

    // Prioritised target mux; only real redirects are alignment-checked.
    always_comb begin
        pc_plus4_o = pc_i + WIDTH'(4);
        br_off     = {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
        next_pc_o  = pc_plus4_o;
        redirect   = 1'b0;
        if (syscall_i) begin
            next_pc_o = pc_plus4_o;
        end else if (jr_i) begin
            next_pc_o = rs_value_i;
            redirect  = 1'b1;
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], inst_i, 2'b00};
            redirect  = 1'b1;
        end else if (branch_i && branch_taken_i) begin
            next_pc_o = pc_plus4_o + br_off;
            redirect  = 1'b1;
        end
        misaligned_o = redirect && (next_pc_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches one word per request from
// instruction memory and presents it to decode for a single issue cycle.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] inst,
    output logic             inst_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] link_addr,
    input  logic             jump_i,
    input  logic             jr_i,
    input  logic             branch_i,
    input  logic             branch_taken_i,
    input  logic             syscall_i,
    input  logic [WIDTH-1:0] rs_value_i,
    input  logic             sys_done_i,
    input  logic             sys_exit_i,
    output logic             halted,
    output logic             misaligned_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;
    logic             target_mis;

    next_pc_calc #(.WIDTH(WIDTH)) u_npc (
        .pc_i           (pc_q),
        .inst_i         (inst_q[TGT_W-1:0]),
        .rs_value_i     (rs_value_i),
        .jump_i         (jump_i),
        .jr_i           (jr_i),
        .branch_i       (branch_i),
        .branch_taken_i (branch_taken_i),
        .syscall_i      (syscall_i),
        .pc_plus4_o     (pc_plus4),
        .next_pc_o      (next_pc),
        .misaligned_o   (target_mis)
    );

    // Next-state logic and state-decoded outputs; reset masks the
    // handshake so a ready seen during reset has no effect.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        mis_d      = mis_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                inst_valid = 1'b1;
                if (syscall_i) begin
                    pc_d    = pc_plus4;
                    state_d = SYS_WAIT;
                end else if (target_mis) begin
                    mis_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            SYS_WAIT: begin
                if (sys_done_i) begin
                    state_d = sys_exit_i ? HALT : FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        if (rst) begin
            imem_req   = 1'b0;
            inst_valid = 1'b0;
            halted     = 1'b0;
        end
    end

    // State, PC, instruction and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign link_addr      = pc_plus4;
    assign misaligned_err = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer. The reference model works
// per instruction: it knows the expected PC and applies the next-PC rules
// with plain arithmetic.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] ADDI   = 32'h2008_0001;

    logic        clk, rst;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] inst, pc, link_addr, rs_value_i;
    logic        inst_valid, halted, misaligned_err;
    logic        jump_i, jr_i, branch_i, branch_taken_i, syscall_i;
    logic        sys_done_i, sys_exit_i;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .pc             (pc),
        .link_addr      (link_addr),
        .jump_i         (jump_i),
        .jr_i           (jr_i),
        .branch_i       (branch_i),
        .branch_taken_i (branch_taken_i),
        .syscall_i      (syscall_i),
        .rs_value_i     (rs_value_i),
        .sys_done_i     (sys_done_i),
        .sys_exit_i     (sys_exit_i),
        .halted         (halted),
        .misaligned_err (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Redirect controls are don't-care outside the issue cycle: scramble them.
    task automatic junk_ctrl();
        jump_i         = 1'($urandom_range(0, 1));
        jr_i           = 1'($urandom_range(0, 1));
        branch_i       = 1'($urandom_range(0, 1));
        branch_taken_i = 1'($urandom_range(0, 1));
        syscall_i      = 1'($urandom_range(0, 1));
        rs_value_i     = $urandom;
    endtask

    task automatic reset_dut(input logic rdy);
        rst        = 1'b1;
        imem_ready = rdy;
        imem_rdata = $urandom;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_vld", inst_valid, 0);
        chk("rst_halt", halted, 0);
        @(negedge clk);
        rst        = 1'b0;
        imem_ready = 1'b0;
        #1;
        chk("rst_inst", inst, 0);
        chk("rst_mis", misaligned_err, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_req1", imem_req, 1);
        exp_pc = RST_PC;
    endtask

    // One instruction end-to-end: fetch with `waits` stall cycles, issue with
    // the given controls, then follow the model into FETCH/SYS_WAIT/HALT.
    // Entered and left shortly after a falling edge.
    task automatic do_inst(input logic [31:0] w, input int waits,
                           input logic j, input logic jr, input logic br,
                           input logic tk, input logic sc, input logic [31:0] rs,
                           input int swait, input logic sexit);
        logic [31:0] p4, tgt;
        logic        redir, mis;
        chk("f_req", imem_req, 1);
        chk("f_addr", imem_addr, exp_pc);
        chk("f_vld", inst_valid, 0);
        repeat (waits) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("w_req", imem_req, 1);
            chk("w_vld", inst_valid, 0);
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("i_vld", inst_valid, 1);
        chk("i_inst", inst, w);
        chk("i_pc", pc, exp_pc);
        chk("i_link", link_addr, exp_pc + 32'd4);
        chk("i_req", imem_req, 0);
        jump_i = j; jr_i = jr; branch_i = br; branch_taken_i = tk;
        syscall_i = sc; rs_value_i = rs;

        p4    = exp_pc + 32'd4;
        tgt   = p4;
        redir = 1'b0;
        if (sc)            tgt = p4;
        else if (jr)       begin tgt = rs; redir = 1'b1; end
        else if (j)        begin tgt = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4); redir = 1'b1; end
        else if (br && tk) begin tgt = p4 + 32'(int'($signed(w[15:0])) * 4); redir = 1'b1; end
        mis = redir && (tgt % 4 != 0);

        @(negedge clk);
        junk_ctrl();
        chk("n_vld", inst_valid, 0);
        if (mis) begin
            chk("m_err", misaligned_err, 1);
            chk("m_halt", halted, 1);
            chk("m_req", imem_req, 0);
            chk("m_pc", pc, exp_pc);
        end else if (sc) begin
            exp_pc = tgt;
            for (int k = 0; k <= swait; k++) begin
                chk("s_req", imem_req, 0);
                chk("s_vld", inst_valid, 0);
                chk("s_halt", halted, 0);
                if (k < swait) @(negedge clk);
            end
            sys_done_i = 1'b1;
            sys_exit_i = sexit;
            @(negedge clk);
            sys_done_i = 1'b0;
            sys_exit_i = 1'($urandom_range(0, 1));
            if (sexit) begin
                chk("x_halt", halted, 1);
                chk("x_req", imem_req, 0);
                chk("x_mis", misaligned_err, 0);
            end
        end else begin
            exp_pc = tgt;
        end
    endtask

    task automatic halt_hold();
        repeat (3) begin
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("h_halt", halted, 1);
            chk("h_req", imem_req, 0);
            chk("h_vld", inst_valid, 0);
        end
        imem_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] w, rs;
        logic        j, jr, br, tk, sc;
        int          r;
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
        sys_done_i = 1'b0; sys_exit_i = 1'b0;
        junk_ctrl();
        exp_pc = RST_PC;

        @(negedge clk);
        reset_dut(1'b1);
        // Sequential ADDIs with a zero-wait memory.
        repeat (4) do_inst(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // BEQ at 0x400010, offset -4 words, taken then not taken.
        chk("beq_at", exp_pc, 32'h0040_0010);
        do_inst(32'h1000_FFFC, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("beq_tk", exp_pc, 32'h0040_0004);
        repeat (3) do_inst(ADDI, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_inst(32'h1000_FFFC, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // JAL at 0x400020 to 0x00100000.
        repeat (3) do_inst(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_at", exp_pc, 32'h0040_0020);
        do_inst(32'h0C04_0000, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_tgt", exp_pc, 32'h0010_0000);
        // JR back to 0x400030, then SYSCALL resume and SYSCALL exit.
        do_inst(32'h03E0_0008, 0, 1, 1, 0, 0, 0, 32'h0040_0030, 0, 0);
        do_inst(32'h0000_000C, 0, 0, 0, 0, 0, 1, 0, 3, 0);
        chk("sys_resume", exp_pc, 32'h0040_0034);
        do_inst(32'h0000_000C, 2, 0, 0, 0, 0, 1, 0, 2, 1);
        halt_hold();

        // Reset with a pending request and a ready in the same cycle.
        reset_dut(1'b0);
        do_inst(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_dut(1'b1);
        // Wrap-around: jump into the top word and fall through to 0.
        do_inst(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        do_inst(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap", exp_pc, 32'h0000_0000);
        // Most negative branch offset.
        do_inst(32'h1000_8000, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("br_min", exp_pc, 32'hFFFE_0004);

        // Random instruction stream with overlapping control flags.
        for (int n = 0; n < 80; n++) begin
            w  = $urandom;
            r  = $urandom_range(0, 9);
            sc = (r == 0);
            jr = (r == 1) || (sc && 1'($urandom_range(0, 1)));
            j  = (r == 2) || (r <= 1 && 1'($urandom_range(0, 1)));
            br = (r >= 3 && r <= 5) || (r <= 2 && 1'($urandom_range(0, 1)));
            tk = 1'($urandom_range(0, 1));
            rs = $urandom & 32'hFFFF_FFFC;
            do_inst(w, $urandom_range(0, 2), j, jr, br, tk, sc, rs,
                    $urandom_range(0, 3), 1'b0);
        end

        // Misaligned JR halts with the sticky error.
        do_inst(32'h03E0_0008, 0, 1, 1, 0, 0, 0, 32'h0040_0102, 0, 0);
        halt_hold();
        chk("m_sticky", misaligned_err, 1);
        reset_dut(1'b1);
        do_inst(ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side counterpart of the decode stage. Owns the PC, fetches words from instruction memory over a req/ready handshake, and presents each instruction to decode for exactly one issue cycle.
- Consumes the decoded redirect/syscall controls in that cycle to select the next PC.
- Sits between instruction memory and decode in the single-issue MIPS core (no delay slots).

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset (text segment base).
- WIDTH, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ready
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched instruction word
- inst  out  32  instruction presented to decode
- inst_valid  out  1  issue cycle; decode outputs are sampled only when high
- pc  out  32  address of inst
- link_addr  out  32  pc+4, written to $ra by JAL
- jump_i  in  1  decoded J/JAL/JR
- jr_i  in  1  decoded JR
- branch_i  in  1  decoded BEQ/BNE
- branch_taken_i  in  1  resolved branch condition from ALU compare
- syscall_i  in  1  decoded SYSCALL
- rs_value_i  in  32  register rs value (JR target)
- sys_done_i  in  1  syscall handler finished; resume
- sys_exit_i  in  1  with sys_done_i: program exit
- halted  out  1  core stopped (exit or error)
- misaligned_err  out  1  sticky; redirect target[1:0] != 0

Behaviour:
- States: FETCH, ISSUE, SYS_WAIT, HALT.
- Reset (any state, including mid-request):
  - pc = RESET_PC; state FETCH.
  - imem_req = 0 in the reset cycle; inst = 0; inst_valid = 0; halted = 0; misaligned_err = 0.
  - An imem_ready arriving during reset is ignored.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ready: latch imem_rdata into inst, go to ISSUE next cycle.
  - Latency: ready at edge N gives inst_valid in cycle N+1. With a 0-wait memory, throughput is 1 instruction per 2 cycles.
- ISSUE:
  - inst_valid = 1 for exactly one cycle; imem_req = 0.
  - Next-PC selection, priority high to low:
    1. syscall_i: pc = pc+4, go to SYS_WAIT.
    2. jr_i: pc = rs_value_i.
    3. jump_i: pc = {pc_plus4[31:28], inst[25:0], 2'b00}.
    4. branch_i & branch_taken_i: pc = pc_plus4 + (sign-extended inst[15:0] << 2).
    5. Otherwise: pc = pc_plus4.
  - If a jr/jump/branch target has target[1:0] != 0: set misaligned_err, go to HALT, pc unchanged.
  - Otherwise return to FETCH.
- Arithmetic and link address:
  - All addition is modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0.
  - Branch offset 16'h8000 yields pc_plus4 - 0x20000.
  - link_addr = pc+4, valid whenever inst_valid is high.
- SYS_WAIT:
  - No fetch; inst_valid = 0.
  - sys_done_i & ~sys_exit_i: go to FETCH.
  - sys_done_i & sys_exit_i: go to HALT.
- HALT:
  - halted = 1, imem_req = 0, inst_valid = 0. Leave only via rst.
- Redirect inputs are don't-care outside ISSUE.
- inst holds its last value outside ISSUE.

Decomposition:
- Shared package / mips.h additions:
  - state encoding constants FETCH, ISSUE, SYS_WAIT, HALT;
  - RESET_PC default;
  - the 26-bit target field select.
- Sub-module next_pc_calc: combinational target computation and alignment check, with inputs pc, inst, rs_value, controls.
- The FSM and PC register stay in fetch_sequencer.

Test Plan:
- Reset, 0-wait memory returning ADDI words:
  - imem_addr is 0x400000, 0x400004, 0x400008;
  - inst_valid pulses every 2nd cycle.
- BEQ at 0x400010, imm 0xFFFC, branch_taken_i = 1 → next imem_addr 0x400004. Same with branch_taken_i = 0 → 0x400014.
- JAL at 0x400020, target 0x040000:
  - link_addr = 0x400024 during issue;
  - next imem_addr 0x00100000.
- JR with rs_value_i 0x400102:
  - misaligned_err = 1 and halted = 1 the next cycle;
  - imem_req stays 0.
- SYSCALL at 0x400030:
  - no imem_req until sys_done_i, then fetch at 0x400034;
  - a second SYSCALL with sys_done_i & sys_exit_i gives halted = 1.
- rst asserted while imem_req is pending and imem_ready arrives in the same cycle: the word is discarded and the next fetch is at 0x400000.
